ru_fault_allocator: RTL and testbench

//   Sits between BIST result capture and the recompute-unit controller. On start, snapshots the
//   STW pass/fail matrix and scans it serially, one PE per cycle, in column-major order.

---
 rtl/ru_fault_allocator_pkg.sv | 15 +
 rtl/ru_fault_allocator_scan_index.sv | 47 ++++
 rtl/ru_fault_allocator.sv | 186 ++++++++++++++++++
 tb/tb_ru_fault_allocator.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ru_fault_allocator_pkg.sv
// Shared constants for the fault allocator: FSM encodings and the {ru_idx, used} column-map field
// layout consumed by the RU controller and the output mux.
package ru_fault_allocator_pkg;

    typedef enum logic [1:0] {
        RA_IDLE = 2'd0,
        RA_SCAN = 2'd1,
        RA_DONE = 2'd2
    } ra_state_e;

    // col_ru_map field layout: used flag in the LSB, RU index above it
    localparam int unsigned MAP_USED_BIT   = 0;
    localparam int unsigned MAP_RU_IDX_LSB = 1;

endpackage

// File: rtl/ru_fault_allocator_scan_index.sv
// Column-major PE scan counter: row advances first, column advances on row wrap.
module ru_scan_index #(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4,
    localparam int unsigned NB_R = $clog2(ROWS),
    localparam int unsigned NB_C = $clog2(COLS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            inc,
    output logic [NB_R-1:0] row,
    output logic [NB_C-1:0] col,
    output logic            wrap,
    output logic            last
);

    localparam logic [NB_R-1:0] ROW_MAX = NB_R'(ROWS - 1);
    localparam logic [NB_C-1:0] COL_MAX = NB_C'(COLS - 1);

    logic [NB_R-1:0] row_q;
    logic [NB_C-1:0] col_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (clear) begin
            row_q <= '0;
            col_q <= '0;
        end else if (inc) begin
            if (row_q == ROW_MAX) begin
                row_q <= '0;
                col_q <= (col_q == COL_MAX) ? '0 : col_q + 1'b1;
            end else begin
                row_q <= row_q + 1'b1;
            end
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign wrap = (row_q == ROW_MAX);
    // last: column index is on its final value
    assign last = (col_q == COL_MAX);

endmodule

// File: rtl/ru_fault_allocator.sv
// Snapshots the BIST pass/fail matrix, scans it column-major and assigns faulty PEs to redundant
// units. Optional macro RU_ALLOC_EARLY_EXIT_EN ends the scan once no faulty PEs remain.
module ru_fault_allocator
    import ru_fault_allocator_pkg::*;
#(
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 4,
    parameter int unsigned NUM_RU = 4,
    localparam int unsigned NB_R  = $clog2(ROWS),
    localparam int unsigned NB_C  = $clog2(COLS),
    localparam int unsigned NB_RU = $clog2(NUM_RU),
    localparam int unsigned NB_F  = $clog2(ROWS * COLS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ROWS*COLS-1:0]      stw_result_mat,
    output logic                      busy,
    output logic                      done,
    output logic                      alloc_valid,
    output logic [NUM_RU-1:0]         ru_en,
    output logic [NB_C*NUM_RU-1:0]    ru_col_mapping,
    output logic [NB_R*NUM_RU-1:0]    ru_row_mapping,
    output logic [COLS*(NB_RU+1)-1:0] col_ru_map,
    output logic [COLS-1:0]           col_multi_fault,
    output logic [NB_F-1:0]           fault_count,
    output logic                      overflow
);

    localparam int unsigned NPE     = ROWS * COLS;
    localparam int unsigned NB_PE   = $clog2(NPE);
    localparam int unsigned NB_NEXT = NB_RU + 1;
    localparam logic [NB_F-1:0]    F_MAX  = NB_F'(NPE);
    localparam logic [NB_NEXT-1:0] RU_MAX = NB_NEXT'(NUM_RU);

    ra_state_e          state_q;
    logic [NPE-1:0]     snap_q;
    logic               busy_q, done_q, valid_q, overflow_q;
    logic [NUM_RU-1:0]  ru_en_q;
    logic [NB_C-1:0]    ru_col_q [NUM_RU];
    logic [NB_R-1:0]    ru_row_q [NUM_RU];
    logic [NB_RU:0]     col_map_q [COLS];
    logic [COLS-1:0]    col_seen_q, col_multi_q;
    logic [NB_F-1:0]    fault_count_q;
    logic [NB_NEXT-1:0] next_ru_q;

    logic [NB_R-1:0]  row;
    logic [NB_C-1:0]  col;
    logic             row_wrap, col_last, scan_end;
    logic [NB_PE-1:0] pe_idx;
    logic [NB_RU-1:0] ru_idx;
    logic             fault;

    ru_scan_index #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_scan_index (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q != RA_SCAN),
        .inc   (state_q == RA_SCAN),
        .row   (row),
        .col   (col),
        .wrap  (row_wrap),
        .last  (col_last)
    );

    assign pe_idx = NB_PE'(row) * NB_PE'(COLS) + NB_PE'(col);
    assign fault  = ~snap_q[pe_idx];
    assign ru_idx = next_ru_q[NB_RU-1:0];

`ifdef RU_ALLOC_EARLY_EXIT_EN
    logic [NPE-1:0] pending_q;
    logic [NPE-1:0] pe_bit;
    assign pe_bit   = NPE'(1) << pe_idx;
    assign scan_end = (row_wrap && col_last) || ((pending_q & ~pe_bit) == '0);
`else
    assign scan_end = row_wrap && col_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RA_IDLE;
            snap_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            valid_q       <= 1'b0;
            overflow_q    <= 1'b0;
            ru_en_q       <= '0;
            col_seen_q    <= '0;
            col_multi_q   <= '0;
            fault_count_q <= '0;
            next_ru_q     <= '0;
            for (int k = 0; k < NUM_RU; k++) begin
                ru_col_q[k] <= '0;
                ru_row_q[k] <= '0;
            end
            for (int c = 0; c < COLS; c++) col_map_q[c] <= '0;
`ifdef RU_ALLOC_EARLY_EXIT_EN
            pending_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                RA_IDLE: begin
                    if (start) begin
                        snap_q        <= stw_result_mat;
                        busy_q        <= 1'b1;
                        valid_q       <= 1'b0;
                        overflow_q    <= 1'b0;
                        ru_en_q       <= '0;
                        col_seen_q    <= '0;
                        col_multi_q   <= '0;
                        fault_count_q <= '0;
                        next_ru_q     <= '0;
                        for (int k = 0; k < NUM_RU; k++) begin
                            ru_col_q[k] <= '0;
                            ru_row_q[k] <= '0;
                        end
                        for (int c = 0; c < COLS; c++) col_map_q[c] <= '0;
`ifdef RU_ALLOC_EARLY_EXIT_EN
                        pending_q <= ~stw_result_mat;
                        if (&stw_result_mat) begin
                            state_q <= RA_DONE;
                            done_q  <= 1'b1;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= RA_SCAN;
                        end
`else
                        state_q <= RA_SCAN;
`endif
                    end
                end
                RA_SCAN: begin
`ifdef RU_ALLOC_EARLY_EXIT_EN
                    pending_q <= pending_q & ~pe_bit;
`endif
                    if (fault) begin
                        if (fault_count_q != F_MAX) fault_count_q <= fault_count_q + 1'b1;
                        // Second fault in a column flags it whether or not it was allocated
                        if (col_seen_q[col]) col_multi_q[col] <= 1'b1;
                        col_seen_q[col] <= 1'b1;
                        if (next_ru_q != RU_MAX) begin
                            ru_en_q[ru_idx]  <= 1'b1;
                            ru_col_q[ru_idx] <= col;
                            ru_row_q[ru_idx] <= row;
                            next_ru_q        <= next_ru_q + 1'b1;
                            if (!col_map_q[col][MAP_USED_BIT]) col_map_q[col] <= {ru_idx, 1'b1};
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
                    if (scan_end) begin
                        state_q <= RA_DONE;
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                    end
                end
                RA_DONE: begin
                    state_q <= RA_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= RA_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_RU; k++) begin : g_ru_out
        assign ru_col_mapping[k*NB_C +: NB_C] = ru_col_q[k];
        assign ru_row_mapping[k*NB_R +: NB_R] = ru_row_q[k];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col_out
        assign col_ru_map[c*(NB_RU+1) +: NB_RU+1] = col_map_q[c];
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign alloc_valid     = valid_q;
    assign ru_en           = ru_en_q;
    assign col_multi_fault = col_multi_q;
    assign fault_count     = fault_count_q;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_ru_fault_allocator.sv
// Self-checking bench for ru_fault_allocator (4x4 array, 4 RUs): vector table plus scoreboard.
module tb_ru_fault_allocator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] stw_result_mat;
    logic        busy, done, alloc_valid, overflow;
    logic [3:0]  ru_en, col_multi_fault;
    logic [7:0]  ru_col_mapping, ru_row_mapping;
    logic [11:0] col_ru_map;
    logic [4:0]  fault_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] mat;
        logic [3:0]  ru_en;
        logic [7:0]  cols;
        logic [7:0]  rows;
        logic [11:0] cmap;
        logic [3:0]  multi;
        logic [4:0]  fc;
        logic        ov;
    } vec_t;

    vec_t vecs[7];
    vec_t sb_q[$];

    ru_fault_allocator dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .stw_result_mat  (stw_result_mat),
        .busy            (busy),
        .done            (done),
        .alloc_valid     (alloc_valid),
        .ru_en           (ru_en),
        .ru_col_mapping  (ru_col_mapping),
        .ru_row_mapping  (ru_row_mapping),
        .col_ru_map      (col_ru_map),
        .col_multi_fault (col_multi_fault),
        .fault_count     (fault_count),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Edges from the start edge until done is visible
    function automatic int exp_lat(input logic [15:0] m);
        int last_f = -1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!m[r*4+c]) last_f = c * 4 + r;
`ifndef RU_ALLOC_EARLY_EXIT_EN
        last_f = 15;
`endif
        return last_f + 1;
    endfunction

    task automatic check_cleared(input string tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".valid"}, alloc_valid, 0);
        check({tag, ".ru_en"}, ru_en, 0);
        check({tag, ".cols"}, ru_col_mapping, 0);
        check({tag, ".rows"}, ru_row_mapping, 0);
        check({tag, ".cmap"}, col_ru_map, 0);
        check({tag, ".multi"}, col_multi_fault, 0);
        check({tag, ".fc"}, fault_count, 0);
        check({tag, ".ov"}, overflow, 0);
    endtask

    task automatic run_vec(input string tag, input vec_t v, input int poke_at,
                           input bit start_in_done);
        int   lat;
        vec_t e;
        stw_result_mat = v.mat;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stw_result_mat = ~v.mat;
        sb_q.push_back(v);
        check({tag, ".start_busy"}, busy, 1);
        check({tag, ".start_ru_en"}, ru_en, 0);
        if (exp_lat(v.mat) > 0) check({tag, ".start_valid"}, alloc_valid, 0);
        lat = 0;
        while (done !== 1'b1 && lat < 64) begin
            start = (lat == poke_at);
            if (start) stw_result_mat = 16'h0000;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({tag, ".latency"}, lat, exp_lat(v.mat));
        check({tag, ".done_valid"}, alloc_valid, 1);
        check({tag, ".done_busy"}, busy, 1);
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s.scoreboard: got empty queue, expected one entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".ru_en"}, ru_en, e.ru_en);
            check({tag, ".cols"}, ru_col_mapping, e.cols);
            check({tag, ".rows"}, ru_row_mapping, e.rows);
            check({tag, ".cmap"}, col_ru_map, e.cmap);
            check({tag, ".multi"}, col_multi_fault, e.multi);
            check({tag, ".fc"}, fault_count, e.fc);
            check({tag, ".ov"}, overflow, e.ov);
        end
        start = start_in_done;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".post_done"}, done, 0);
        check({tag, ".post_busy"}, busy, 0);
        check({tag, ".post_valid"}, alloc_valid, 1);
        check({tag, ".post_ru_en"}, ru_en, e.ru_en);
    endtask

    initial begin
        // mat, ru_en, cols, rows, cmap, multi, fc, ov
        vecs[0] = '{16'hFFFF, 4'h0, 8'h00, 8'h00, 12'h000, 4'h0, 5'd0,  1'b0}; // all pass
        vecs[1] = '{16'hEFBF, 4'h3, 8'h08, 8'h07, 12'h0C1, 4'h0, 5'd2,  1'b0}; // (1,2),(3,0)
        vecs[2] = '{16'hFDFD, 4'h3, 8'h05, 8'h08, 12'h008, 4'h2, 5'd2,  1'b0}; // (0,1),(2,1)
        vecs[3] = '{16'h7BD6, 4'hF, 8'hE4, 8'h24, 12'hF59, 4'h8, 5'd5,  1'b1}; // 5 faults
        vecs[4] = '{16'h0000, 4'hF, 8'h00, 8'hE4, 12'h001, 4'hF, 5'd16, 1'b1}; // all faulty
        vecs[5] = '{16'h7FFF, 4'h1, 8'h03, 8'h03, 12'h200, 4'h0, 5'd1,  1'b0}; // last PE
        vecs[6] = '{16'hFFFE, 4'h1, 8'h00, 8'h00, 12'h001, 4'h0, 5'd1,  1'b0}; // first PE

        rst_n = 1'b0;
        start = 1'b0;
        stw_result_mat = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i], -1, 1'b0);

        // start pulsed mid-scan and held during the DONE cycle must both be ignored
        run_vec("busy_start", vecs[1], 3, 1'b1);

        // reset in the middle of a scan
        stw_result_mat = vecs[3].mat;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid.busy", busy, 1);
        check("mid.fc", fault_count, 1);
        check("mid.ru_en", ru_en, 4'h1);
        check("mid.valid", alloc_valid, 0);
        rst_n = 1'b0;
        #1;
        check_cleared("mid_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_cleared("post_rst");

        run_vec("recover", vecs[3], -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
